ex_mem_stage: RTL and testbench

//  EX->MEM pipeline register with branch resolution. Sits directly downstream of the 64-bit ALU:

---
 rtl/ex_mem_stage_if.sv | 40 ++++
 rtl/ex_mem_stage.sv | 132 +++++++++++++
 tb/tb_ex_mem_stage.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if
//  Bus between the EX/MEM pipeline register and the MEM stage.
//  master : pipeline register side (drives the held op, samples mem_ready)
//  slave  : MEM stage side (consumes the held op, drives mem_ready)
//  Signals:
//   mem_valid    held op valid
//   mem_ready    MEM consumes the held op this cycle
//   mem_addr     held ALU result
//   mem_wdata    held store data
//   mem_rd       held destination register
//   mem_rd_en    load enable, gated by mem_valid
//   mem_wr_en    store enable, gated by mem_valid
//   mem_reg_wr   register write enable, gated by mem_valid
//   mem_mem2reg  writeback source select (held, not gated)
interface ex_mem_stage_if #(
    parameter int DATA_W = 64,
    parameter int RA_W   = 5
);
    logic              mem_valid;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [RA_W-1:0]   mem_rd;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic              mem_reg_wr;
    logic              mem_mem2reg;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_rd,
               mem_rd_en, mem_wr_en, mem_reg_wr, mem_mem2reg,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_rd,
               mem_rd_en, mem_wr_en, mem_reg_wr, mem_mem2reg,
        output mem_ready
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//  EX->MEM pipeline register with branch resolution. Captures the ALU
//  result, store data, rd and control bits of an accepted op, resolves
//  B/CBZ/CBNZ from the ALU zero flag, drops the single op that follows a
//  taken branch, obeys the hazard-unit flush and counts retired/dropped ops.
//  Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid / ex_ready   EX-side handshake
//   alu_result, alu_zero  ALU outputs
//   store_data, rd        STUR data, destination register
//   br_target             precomputed PC+offset
//   ctl_*                 decoded control bits of the op
//   flush                 hazard-unit flush of this stage
//   br_taken, br_pc       one-cycle redirect pulse and its target
//   retire_cnt            MEM handshakes
//   squash_cnt            ops dropped after a taken branch
//   mem                   MEM-side bus (master modport)
module ex_mem_stage #(
    parameter int DATA_W = 64,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [RA_W-1:0]   rd,
    input  logic [DATA_W-1:0] br_target,
    input  logic              ctl_mem_rd,
    input  logic              ctl_mem_wr,
    input  logic              ctl_reg_wr,
    input  logic              ctl_mem2reg,
    input  logic              ctl_branch,
    input  logic              ctl_br_nz,
    input  logic              ctl_uncond,
    input  logic              flush,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_pc,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  squash_cnt,
    ex_mem_stage_if.master    mem
);

    logic              valid_q;
    logic              br_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [RA_W-1:0]   rd_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              reg_wr_q;
    logic              mem2reg_q;
    logic [DATA_W-1:0] pc_q;
    logic [CNT_W-1:0]  retire_q;
    logic [CNT_W-1:0]  squash_q;

    logic accept;
    logic take;
    logic retire;

    assign ex_ready = ~flush & (~valid_q | mem.mem_ready);
    assign accept   = ex_valid & ex_ready;
    // CBZ takes on zero, CBNZ on non-zero; B always takes.
    assign take     = ctl_uncond | (ctl_branch & (alu_zero ^ ctl_br_nz));
    assign retire   = valid_q & mem.mem_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            br_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            reg_wr_q  <= 1'b0;
            mem2reg_q <= 1'b0;
            pc_q      <= '0;
            retire_q  <= '0;
            squash_q  <= '0;
        end else begin
            if (retire) begin
                retire_q <= retire_q + CNT_W'(1);
            end

            if (flush) begin
                valid_q <= 1'b0;
                br_q    <= 1'b0;
            end else if (accept && br_q) begin
                // Wrong-path op right behind a taken branch: consume, don't capture.
                valid_q  <= 1'b0;
                br_q     <= 1'b0;
                squash_q <= squash_q + CNT_W'(1);
            end else if (accept) begin
                valid_q   <= 1'b1;
                br_q      <= take;
                addr_q    <= alu_result;
                wdata_q   <= store_data;
                rd_q      <= rd;
                mem_rd_q  <= ctl_mem_rd;
                mem_wr_q  <= ctl_mem_wr;
                reg_wr_q  <= ctl_reg_wr;
                mem2reg_q <= ctl_mem2reg;
                pc_q      <= br_target;
            end else if (valid_q && mem.mem_ready) begin
                valid_q <= 1'b0;
                br_q    <= 1'b0;
            end else begin
                // Redirect is a single-cycle pulse even while MEM stalls.
                br_q <= 1'b0;
            end
        end
    end

    assign mem.mem_valid   = valid_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_wdata   = wdata_q;
    assign mem.mem_rd      = rd_q;
    assign mem.mem_rd_en   = mem_rd_q & valid_q;
    assign mem.mem_wr_en   = mem_wr_q & valid_q;
    assign mem.mem_reg_wr  = reg_wr_q & valid_q;
    assign mem.mem_mem2reg = mem2reg_q;

    assign br_taken   = br_q;
    assign br_pc      = pc_q;
    assign retire_cnt = retire_q;
    assign squash_cnt = squash_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed vector table, hand-written stall and
// reset sequences, then randomized traffic against a queue-based model.
module tb_ex_mem_stage;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] tgt;
        logic [4:0]  rd;
        logic        mrd, mwr, rwr, m2r, branch, nz, unc, zero;
    } op_t;

    typedef struct {
        logic        ev, fl, mr;
        op_t         op;
        logic        exp_rdy, exp_mv;
        logic [63:0] exp_addr;
        logic [4:0]  exp_rd;
        logic        exp_br;
        logic [63:0] exp_pc;
        logic        exp_wr;
        int          exp_ret, exp_sq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [63:0] alu_result = '0;
    logic        alu_zero = 1'b0;
    logic [63:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic [63:0] br_target = '0;
    logic        ctl_mem_rd = 1'b0, ctl_mem_wr = 1'b0, ctl_reg_wr = 1'b0;
    logic        ctl_mem2reg = 1'b0, ctl_branch = 1'b0, ctl_br_nz = 1'b0;
    logic        ctl_uncond = 1'b0;
    logic        flush = 1'b0;
    logic        br_taken;
    logic [63:0] br_pc;
    logic [31:0] retire_cnt, squash_cnt;

    ex_mem_stage_if #(.DATA_W(64), .RA_W(5)) mem_bus ();

    ex_mem_stage #(.DATA_W(64), .RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .store_data(store_data),
        .rd(rd), .br_target(br_target), .ctl_mem_rd(ctl_mem_rd),
        .ctl_mem_wr(ctl_mem_wr), .ctl_reg_wr(ctl_reg_wr),
        .ctl_mem2reg(ctl_mem2reg), .ctl_branch(ctl_branch),
        .ctl_br_nz(ctl_br_nz), .ctl_uncond(ctl_uncond), .flush(flush),
        .br_taken(br_taken), .br_pc(br_pc), .retire_cnt(retire_cnt),
        .squash_cnt(squash_cnt), .mem(mem_bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mkop(logic [63:0] addr, logic [63:0] wdata, logic [4:0] r,
                                 logic [63:0] tgt, logic z, logic [6:0] ctl);
        op_t o;
        o.addr = addr; o.wdata = wdata; o.rd = r; o.tgt = tgt; o.zero = z;
        {o.mrd, o.mwr, o.rwr, o.m2r, o.branch, o.nz, o.unc} = ctl;
        return o;
    endfunction

    function automatic vec_t mkv(logic ev, logic fl, logic mr, op_t op, logic rdy, logic mv,
                                 logic [63:0] addr, logic [4:0] r, logic br, logic [63:0] pc,
                                 logic wr, int ret, int sq);
        vec_t v;
        v.ev = ev; v.fl = fl; v.mr = mr; v.op = op;
        v.exp_rdy = rdy; v.exp_mv = mv; v.exp_addr = addr; v.exp_rd = r;
        v.exp_br = br; v.exp_pc = pc; v.exp_wr = wr; v.exp_ret = ret; v.exp_sq = sq;
        return v;
    endfunction

    task automatic drive(input logic ev, input logic fl, input logic mr, input op_t o);
        ex_valid = ev; flush = fl; mem_bus.mem_ready = mr;
        alu_result = o.addr; store_data = o.wdata; br_target = o.tgt; rd = o.rd;
        alu_zero = o.zero;
        ctl_mem_rd = o.mrd; ctl_mem_wr = o.mwr; ctl_reg_wr = o.rwr; ctl_mem2reg = o.m2r;
        ctl_branch = o.branch; ctl_br_nz = o.nz; ctl_uncond = o.unc;
    endtask

    // Reference model: the held op lives in a queue of depth 0/1; data
    // outputs show the most recently captured op.
    op_t         held[$];
    op_t         last;
    bit          pulse;
    int unsigned m_ret, m_sq;

    function automatic bit branch_taken(op_t o);
        if (o.unc) return 1'b1;
        if (!o.branch) return 1'b0;
        return o.nz ? !o.zero : o.zero;
    endfunction

    function automatic bit model_ready(bit fl, bit mr);
        return !fl && (held.size() == 0 || mr);
    endfunction

    task automatic model_reset();
        held.delete();
        last = mkop(0, 0, 0, 0, 0, 7'b0);
        pulse = 0; m_ret = 0; m_sq = 0;
    endtask

    task automatic model_step(input bit ev, input bit fl, input bit mr, input op_t cur);
        bit acc;
        acc = ev && model_ready(fl, mr);
        if (!fl && held.size() != 0 && mr) begin
            void'(held.pop_front());
            m_ret++;
        end
        if (fl) begin
            held.delete();
            pulse = 0;
        end else if (acc) begin
            if (pulse) begin
                m_sq++;
                pulse = 0;
            end else begin
                held.push_back(cur);
                last = cur;
                pulse = branch_taken(cur);
            end
        end else begin
            pulse = 0;
        end
    endtask

    task automatic compare_model(input string tag);
        bit mv;
        mv = (held.size() != 0);
        chk({tag, ".mem_valid"},   64'(mem_bus.mem_valid), 64'(mv));
        chk({tag, ".mem_addr"},    mem_bus.mem_addr, last.addr);
        chk({tag, ".mem_wdata"},   mem_bus.mem_wdata, last.wdata);
        chk({tag, ".mem_rd"},      64'(mem_bus.mem_rd), 64'(last.rd));
        chk({tag, ".mem_rd_en"},   64'(mem_bus.mem_rd_en), 64'(mv && last.mrd));
        chk({tag, ".mem_wr_en"},   64'(mem_bus.mem_wr_en), 64'(mv && last.mwr));
        chk({tag, ".mem_reg_wr"},  64'(mem_bus.mem_reg_wr), 64'(mv && last.rwr));
        chk({tag, ".mem_mem2reg"}, 64'(mem_bus.mem_mem2reg), 64'(last.m2r));
        chk({tag, ".br_taken"},    64'(br_taken), 64'(pulse));
        chk({tag, ".br_pc"},       br_pc, last.tgt);
        chk({tag, ".retire_cnt"},  64'(retire_cnt), 64'(m_ret));
        chk({tag, ".squash_cnt"},  64'(squash_cnt), 64'(m_sq));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".mem_valid"},  64'(mem_bus.mem_valid), 64'(0));
        chk({tag, ".mem_addr"},   mem_bus.mem_addr, 64'(0));
        chk({tag, ".mem_wdata"},  mem_bus.mem_wdata, 64'(0));
        chk({tag, ".mem_wr_en"},  64'(mem_bus.mem_wr_en), 64'(0));
        chk({tag, ".br_taken"},   64'(br_taken), 64'(0));
        chk({tag, ".br_pc"},      br_pc, 64'(0));
        chk({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(0));
        chk({tag, ".squash_cnt"}, 64'(squash_cnt), 64'(0));
    endtask

    localparam logic [6:0] C_NOP  = 7'b0000000;
    localparam logic [6:0] C_ADD  = 7'b0010000;
    localparam logic [6:0] C_STUR = 7'b0100000;
    localparam logic [6:0] C_CBZ  = 7'b0000100;
    localparam logic [6:0] C_CBNZ = 7'b0000110;
    localparam logic [6:0] C_B    = 7'b0000001;

    vec_t vecs[12];
    op_t  nop, o1, o2;
    logic [63:0] wd;

    initial begin
        mem_bus.mem_ready = 1'b0;
        nop = mkop(0, 0, 0, 0, 0, C_NOP);

        vecs[0]  = mkv(1,0,1, mkop(64'h8,0,9,0,0,C_ADD),        1,1,64'h8,9,0,64'h0,0,0,0);
        vecs[1]  = mkv(0,0,1, nop,                              1,0,64'h8,9,0,64'h0,0,1,0);
        vecs[2]  = mkv(1,0,1, mkop(0,0,0,64'h100,1,C_CBZ),      1,1,64'h0,0,1,64'h100,0,1,0);
        vecs[3]  = mkv(1,0,1, mkop(64'h77,0,3,0,0,C_ADD),       1,0,64'h0,0,0,64'h100,0,2,1);
        vecs[4]  = mkv(1,0,0, mkop(0,0,0,64'h200,1,C_CBNZ),     1,1,64'h0,0,0,64'h200,0,2,1);
        vecs[5]  = mkv(1,0,0, mkop(64'h40,64'hDEAD,0,0,0,C_STUR),0,1,64'h0,0,0,64'h200,0,2,1);
        vecs[6]  = mkv(1,0,1, mkop(64'h40,64'hDEAD,0,0,0,C_STUR),1,1,64'h40,0,0,64'h0,1,3,1);
        vecs[7]  = mkv(1,1,1, mkop(64'h55,0,7,0,0,C_ADD),       0,0,64'h40,0,0,64'h0,0,3,1);
        vecs[8]  = mkv(1,0,0, mkop(64'h5,0,0,64'h300,0,C_B),    1,1,64'h5,0,1,64'h300,0,3,1);
        vecs[9]  = mkv(0,0,0, nop,                              0,1,64'h5,0,0,64'h300,0,3,1);
        vecs[10] = mkv(1,0,1, mkop(64'h9,0,0,0,0,C_ADD),        1,1,64'h9,0,0,64'h0,0,4,1);
        vecs[11] = mkv(0,0,1, nop,                              1,0,64'h9,0,0,64'h0,0,5,1);

        // Reset
        drive(0, 0, 0, nop);
        rst_n = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("reset.ex_ready", 64'(ex_ready), 64'(1));
        tick();
        chk("post_reset.mem_valid", 64'(mem_bus.mem_valid), 64'(0));
        chk("post_reset.ex_ready", 64'(ex_ready), 64'(1));

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ev, vecs[i].fl, vecs[i].mr, vecs[i].op);
            #1;
            chk($sformatf("vec%0d.ex_ready", i), 64'(ex_ready), 64'(vecs[i].exp_rdy));
            tick();
            chk($sformatf("vec%0d.mem_valid", i), 64'(mem_bus.mem_valid), 64'(vecs[i].exp_mv));
            chk($sformatf("vec%0d.mem_addr", i), mem_bus.mem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d.mem_rd", i), 64'(mem_bus.mem_rd), 64'(vecs[i].exp_rd));
            chk($sformatf("vec%0d.br_taken", i), 64'(br_taken), 64'(vecs[i].exp_br));
            chk($sformatf("vec%0d.br_pc", i), br_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d.mem_wr_en", i), 64'(mem_bus.mem_wr_en), 64'(vecs[i].exp_wr));
            chk($sformatf("vec%0d.retire_cnt", i), 64'(retire_cnt), 64'(vecs[i].exp_ret));
            chk($sformatf("vec%0d.squash_cnt", i), 64'(squash_cnt), 64'(vecs[i].exp_sq));
        end

        // Store held through a 3-cycle MEM stall, then back-to-back
        wd = 64'h1234_5678_9ABC_DEF0;
        o1 = mkop(64'h88, wd, 0, 0, 0, C_STUR);
        o2 = mkop(64'h99, 0, 4, 0, 0, C_ADD);
        drive(1, 0, 0, o1);
        tick();
        chk("stall.first_wr_en", 64'(mem_bus.mem_wr_en), 64'(1));
        drive(1, 0, 0, o2);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d.ex_ready", c), 64'(ex_ready), 64'(0));
            tick();
            chk($sformatf("stall%0d.mem_wr_en", c), 64'(mem_bus.mem_wr_en), 64'(1));
            chk($sformatf("stall%0d.mem_wdata", c), mem_bus.mem_wdata, wd);
            chk($sformatf("stall%0d.mem_addr", c), mem_bus.mem_addr, 64'h88);
        end
        mem_bus.mem_ready = 1'b1;
        #1;
        chk("b2b.ex_ready", 64'(ex_ready), 64'(1));
        tick();
        chk("b2b.mem_valid", 64'(mem_bus.mem_valid), 64'(1));
        chk("b2b.mem_addr", mem_bus.mem_addr, 64'h99);
        chk("b2b.mem_rd", 64'(mem_bus.mem_rd), 64'(4));
        chk("b2b.mem_wr_en", 64'(mem_bus.mem_wr_en), 64'(0));
        chk("b2b.mem_reg_wr", 64'(mem_bus.mem_reg_wr), 64'(1));
        chk("b2b.retire_cnt", 64'(retire_cnt), 64'(6));
        drive(0, 0, 1, nop);
        tick();
        chk("drain.mem_valid", 64'(mem_bus.mem_valid), 64'(0));
        chk("drain.retire_cnt", 64'(retire_cnt), 64'(7));

        // Async reset while stalled with a branch pulse live
        drive(1, 0, 0, mkop(0, 0, 0, 64'h400, 0, C_B));
        tick();
        chk("pre_rst.br_taken", 64'(br_taken), 64'(1));
        chk("pre_rst.br_pc", br_pc, 64'h400);
        drive(0, 0, 0, nop);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk("midrst_rel.ex_ready", 64'(ex_ready), 64'(1));
        chk("midrst_rel.mem_valid", 64'(mem_bus.mem_valid), 64'(0));

        // Randomized traffic against the model
        model_reset();
        for (int n = 0; n < 400; n++) begin
            bit ev, fl, mr;
            op_t o;
            logic [6:0] ctl;
            ev = ($urandom_range(99) < 75);
            fl = ($urandom_range(99) < 10);
            mr = ($urandom_range(99) < 70);
            ctl = 7'($urandom);
            ctl[2] = ($urandom_range(99) < 25);
            ctl[0] = ($urandom_range(99) < 10);
            o = mkop({$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                     {$urandom, $urandom}, 1'($urandom), ctl);
            drive(ev, fl, mr, o);
            #1;
            chk($sformatf("rnd%0d.ex_ready", n), 64'(ex_ready), 64'(model_ready(fl, mr)));
            tick();
            model_step(ev, fl, mr, o);
            compare_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
